// File: rtl/cpu_pkg.sv
// +----------------------------------------------------------------------------+
// | Module : cpu_pkg                                                           |
// | Brief  : Shared CPU constants: condition codes, flag indices, FSM states.  |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package cpu_pkg;

    localparam logic [2:0] COND_NE     = 3'b000;
    localparam logic [2:0] COND_EQ     = 3'b001;
    localparam logic [2:0] COND_GT     = 3'b010;
    localparam logic [2:0] COND_LT     = 3'b011;
    localparam logic [2:0] COND_GE     = 3'b100;
    localparam logic [2:0] COND_LE     = 3'b101;
    localparam logic [2:0] COND_OV     = 3'b110;
    localparam logic [2:0] COND_UNCOND = 3'b111;

    // Bit positions inside the {Z,V,N} flag vector
    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_N = 0;

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } pc_state_t;

    localparam logic [15:0] C_RESET_PC = 16'h0000;

endpackage

`default_nettype wire

// File: rtl/pc_fetch_control_if.sv
// +----------------------------------------------------------------------------+
// | Module : pc_fetch_control_if                                               |
// | Brief  : Decoder/imem-side bundle for the PC fetch stage.                  |
// |          PC_PERF_CNT_EN adds the retired/taken counter outputs.            |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

interface pc_fetch_control_if #(
    parameter int PC_W = 16
);
    logic            imem_rdy;
    logic            halt;
    logic            ben;
    logic            br;
    logic [2:0]      cond;
    logic [8:0]      imm9;
    logic [PC_W-1:0] br_target;
    logic [2:0]      flag_in;
    logic [2:0]      flag_we;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pc_plus2;
    logic [2:0]      flags;
    logic            branch_taken;
    logic            retire;
    logic            halted;
`ifdef PC_PERF_CNT_EN
    logic [31:0]     retired_cnt;
    logic [31:0]     taken_cnt;

    modport master (
        output imem_rdy, halt, ben, br, cond, imm9, br_target, flag_in, flag_we,
        input  pc, pc_plus2, flags, branch_taken, retire, halted,
        input  retired_cnt, taken_cnt
    );
    modport slave (
        input  imem_rdy, halt, ben, br, cond, imm9, br_target, flag_in, flag_we,
        output pc, pc_plus2, flags, branch_taken, retire, halted,
        output retired_cnt, taken_cnt
    );
`else
    modport master (
        output imem_rdy, halt, ben, br, cond, imm9, br_target, flag_in, flag_we,
        input  pc, pc_plus2, flags, branch_taken, retire, halted
    );
    modport slave (
        input  imem_rdy, halt, ben, br, cond, imm9, br_target, flag_in, flag_we,
        output pc, pc_plus2, flags, branch_taken, retire, halted
    );
`endif

endinterface

`default_nettype wire

// File: rtl/pc_branch_cond.sv
// +----------------------------------------------------------------------------+
// | Module : pc_branch_cond                                                    |
// | Brief  : Evaluates a 3-bit condition code against the {Z,V,N} flags.       |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module pc_branch_cond
    import cpu_pkg::*;
(
    input  wire logic [2:0] cond,
    input  wire logic [2:0] flags,
    output logic            cond_true
);

    logic w_z;
    logic w_v;
    logic w_n;

    assign w_z = flags[FLAG_Z];
    assign w_v = flags[FLAG_V];
    assign w_n = flags[FLAG_N];

    always_comb begin
        cond_true = 1'b1;
        case (cond)
            COND_NE:     cond_true = !w_z;
            COND_EQ:     cond_true = w_z;
            COND_GT:     cond_true = !w_z && !w_n;
            COND_LT:     cond_true = w_n;
            COND_GE:     cond_true = w_z || (!w_z && !w_n);
            COND_LE:     cond_true = w_z || w_n;
            COND_OV:     cond_true = w_v;
            COND_UNCOND: cond_true = 1'b1;
            default:     cond_true = 1'b1;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/pc_fetch_control.sv
// +----------------------------------------------------------------------------+
// | Module : pc_fetch_control                                                  |
// | Brief  : PC + flag register stage: next-PC select, branch resolve, halt.   |
// |          Define PC_PERF_CNT_EN for saturating retired/taken counters.      |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module pc_fetch_control
    import cpu_pkg::*;
#(
    parameter int              PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(C_RESET_PC)
)(
    input wire logic          clk,
    input wire logic          rst,
    pc_fetch_control_if.slave bus
);

    pc_state_t       r_state;
    pc_state_t       w_state_nxt;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_pc_nxt;
    logic [PC_W-1:0] w_pc_plus2;
    logic [PC_W-1:0] w_imm_sext;
    logic [PC_W-1:0] w_b_target;
    logic [2:0]      r_flags;
    logic [2:0]      w_flags_nxt;
    logic            w_retire;
    logic            w_cond_true;
    logic            w_taken;

    // Conditions always see the registered flags, so a same-cycle flag write
    // cannot influence the branch it accompanies.
    pc_branch_cond u_branch_cond (
        .cond      (bus.cond),
        .flags     (r_flags),
        .cond_true (w_cond_true)
    );

    assign w_retire   = (r_state == ST_RUN) && bus.imem_rdy;
    assign w_pc_plus2 = r_pc + PC_W'(2);
    assign w_imm_sext = {{(PC_W-9){bus.imm9[8]}}, bus.imm9};
    assign w_b_target = w_pc_plus2 + {w_imm_sext[PC_W-2:0], 1'b0};
    assign w_taken    = w_retire && bus.ben && w_cond_true && !bus.halt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_RUN;
            r_pc    <= RESET_PC;
            r_flags <= 3'b000;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_flags <= w_flags_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_flags_nxt = r_flags;
        case (r_state)
            ST_RUN: begin
                if (w_retire) begin
                    for (int i = 0; i < 3; i++) begin
                        if (bus.flag_we[i]) w_flags_nxt[i] = bus.flag_in[i];
                    end
                    // A halting instruction leaves pc on the HLT word itself
                    if (bus.halt)   w_state_nxt = ST_HALTED;
                    else if (w_taken) w_pc_nxt  = bus.br ? bus.br_target : w_b_target;
                    else            w_pc_nxt    = w_pc_plus2;
                end
            end
            ST_HALTED: w_state_nxt = ST_HALTED;
        endcase
    end

    assign bus.pc           = r_pc;
    assign bus.pc_plus2     = w_pc_plus2;
    assign bus.flags        = r_flags;
    assign bus.branch_taken = w_taken;
    assign bus.retire       = w_retire;
    assign bus.halted       = (r_state == ST_HALTED);

`ifdef PC_PERF_CNT_EN
    logic [31:0] r_retired_cnt;
    logic [31:0] r_taken_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_retired_cnt <= '0;
            r_taken_cnt   <= '0;
        end else begin
            if (w_retire && (r_retired_cnt != 32'hFFFF_FFFF)) r_retired_cnt <= r_retired_cnt + 32'd1;
            if (w_taken && (r_taken_cnt != 32'hFFFF_FFFF))    r_taken_cnt   <= r_taken_cnt + 32'd1;
        end
    end

    assign bus.retired_cnt = r_retired_cnt;
    assign bus.taken_cnt   = r_taken_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pc_fetch_control.sv
// +----------------------------------------------------------------------------+
// | Module : tb_pc_fetch_control                                               |
// | Brief  : Scoreboard bench for pc_fetch_control (directed + random).        |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_pc_fetch_control;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    pc_fetch_control_if #(.PC_W(16)) bus ();

    pc_fetch_control #(.PC_W(16), .RESET_PC(16'h0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic [15:0] pc;
        logic [15:0] pc2;
        logic [2:0]  flags;
        logic        retire;
        logic        taken;
        logic        halted;
        logic [31:0] rc;
        logic [31:0] tc;
    } exp_t;

    exp_t q[$];

    // Architectural reference state
    logic [15:0] m_pc;
    logic [2:0]  m_flags;
    bit          m_halted;
    logic [31:0] m_rc;
    logic [31:0] m_tc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit cond_ok(input logic [2:0] c, input logic [2:0] f);
        bit z, v, n;
        z = f[2]; v = f[1]; n = f[0];
        case (c)
            3'd0:    return !z;
            3'd1:    return z;
            3'd2:    return !z && !n;
            3'd3:    return n;
            3'd4:    return z || (!z && !n);
            3'd5:    return z || n;
            3'd6:    return v;
            default: return 1'b1;
        endcase
    endfunction

    task automatic model_reset();
        m_pc = 16'h0000; m_flags = 3'b000; m_halted = 1'b0; m_rc = 0; m_tc = 0;
    endtask

    task automatic set_idle();
        bus.imem_rdy = 0; bus.halt = 0; bus.ben = 0; bus.br = 0; bus.cond = 0;
        bus.imm9 = 0; bus.br_target = 0; bus.flag_in = 0; bus.flag_we = 0;
    endtask

    // One clock of stimulus; the expected outputs for this cycle go to the scoreboard
    task automatic step(input bit rdy, input bit h, input bit b, input bit brr,
                        input logic [2:0] c, input logic [8:0] imm,
                        input logic [15:0] tgt, input logic [2:0] fi, input logic [2:0] fwe);
        exp_t e;
        logic signed [8:0] simm;
        int off;
        @(posedge clk); #1;
        bus.imem_rdy = rdy; bus.halt = h; bus.ben = b; bus.br = brr; bus.cond = c;
        bus.imm9 = imm; bus.br_target = tgt; bus.flag_in = fi; bus.flag_we = fwe;
        e.pc = m_pc; e.pc2 = m_pc + 16'd2; e.flags = m_flags; e.halted = m_halted;
        e.retire = !m_halted && rdy;
        e.taken  = e.retire && b && cond_ok(c, m_flags) && !h;
        e.rc = m_rc; e.tc = m_tc;
        q.push_back(e);
        if (e.retire) begin
            simm = imm; off = simm;
            if (h)            m_halted = 1'b1;
            else if (e.taken) m_pc = brr ? tgt : m_pc + 16'd2 + 16'(off * 2);
            else              m_pc = m_pc + 16'd2;
            m_flags = (m_flags & ~fwe) | (fi & fwe);
            if (m_rc != 32'hFFFF_FFFF) m_rc = m_rc + 1;
            if (e.taken && m_tc != 32'hFFFF_FFFF) m_tc = m_tc + 1;
        end
    endtask

    task automatic idle1();
        step(1, 0, 0, 0, 3'd0, 9'd0, 16'h0, 3'd0, 3'd0);
    endtask

    task automatic br_to(input logic [15:0] tgt, input logic [2:0] fi, input logic [2:0] fwe);
        step(1, 0, 1, 1, 3'd7, 9'd0, tgt, fi, fwe);
    endtask

    // Asynchronous reset asserted between clock edges; effect must be immediate
    task automatic do_reset();
        @(posedge clk); #7;
        rst = 1'b1;
        #1;
        chk("async_rst_pc", {16'h0, bus.pc}, 32'h0000);
        chk("async_rst_halted", {31'h0, bus.halted}, 32'h0);
        chk("async_rst_flags", {29'h0, bus.flags}, 32'h0);
        set_idle();
        model_reset();
        @(posedge clk); #3;
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("pc", {16'h0, bus.pc}, {16'h0, e.pc});
            chk("pc_plus2", {16'h0, bus.pc_plus2}, {16'h0, e.pc2});
            chk("flags", {29'h0, bus.flags}, {29'h0, e.flags});
            chk("retire", {31'h0, bus.retire}, {31'h0, e.retire});
            chk("branch_taken", {31'h0, bus.branch_taken}, {31'h0, e.taken});
            chk("halted", {31'h0, bus.halted}, {31'h0, e.halted});
`ifdef PC_PERF_CNT_EN
            chk("retired_cnt", bus.retired_cnt, e.rc);
            chk("taken_cnt", bus.taken_cnt, e.tc);
`endif
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        set_idle();
        model_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #3;
        chk("reset_pc", {16'h0, bus.pc}, 32'h0000);
        chk("reset_halted", {31'h0, bus.halted}, 32'h0);
        rst = 1'b0;

        // Sequential fetch
        repeat (4) idle1();
        // B, negative offset, Z set alongside the BR that places pc
        br_to(16'h0010, 3'b100, 3'b100);
        step(1, 0, 1, 0, 3'b001, 9'h1FC, 16'h0, 3'd0, 3'd0);
        br_to(16'h0010, 3'd0, 3'd0);
        step(1, 0, 1, 0, 3'b000, 9'h1FC, 16'h0, 3'd0, 3'd0);
        // BR and flag write in the same cycle as a conditional branch
        br_to(16'h1234, 3'b000, 3'b111);
        step(1, 0, 1, 0, 3'b001, 9'h010, 16'h0, 3'b100, 3'b100);
        idle1();
        // Stall holds pc and flags
        br_to(16'h0040, 3'd0, 3'd0);
        repeat (3) step(0, 0, 0, 0, 3'd0, 9'd0, 16'h0, 3'b101, 3'b111);
        idle1();
        // Halt beats an always-taken branch, then inputs are ignored
        br_to(16'h0020, 3'd0, 3'd0);
        step(1, 1, 1, 0, 3'b111, 9'h004, 16'h0, 3'b111, 3'b111);
        repeat (3) step(1, 0, 1, 1, 3'b111, 9'd0, 16'h5555, 3'b111, 3'b111);
        do_reset();
        // Wrap, then five retires with two taken branches
        br_to(16'hFFFE, 3'd0, 3'd0);
        idle1();
        idle1();
        do_reset();
        idle1();
        br_to(16'h0100, 3'd0, 3'd0);
        idle1();
        step(1, 0, 1, 0, 3'b111, 9'h002, 16'h0, 3'd0, 3'd0);
        idle1();
        step(0, 0, 0, 0, 3'd0, 9'd0, 16'h0, 3'd0, 3'd0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            if (m_halted && ($urandom_range(0, 3) == 0)) begin
                do_reset();
            end else begin
                step($urandom_range(0, 3) != 0, $urandom_range(0, 40) == 0,
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     3'($urandom), 9'($urandom), 16'($urandom),
                     3'($urandom), 3'($urandom));
            end
        end

        @(posedge clk); #1;
        set_idle();
        @(negedge clk); #1;
        chk("scoreboard_drained", q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pc_fetch_control.md
Name: pc_fetch_control

Overview:
- Program-counter and flag-register stage that consumes the main control decoder's halt/BEn/Br/PCS-related outputs and produces the fetch address for instruction memory.
- Holds the architectural PC and the Z/V/N flag register.
- Evaluates branch conditions, computes the next PC (sequential, PC-relative B, register BR) and latches the halt state.
- Sits between the instruction-memory port and the control decoder.

Parameters:
- PC_W, 16, width of PC and all address paths.
- RESET_PC, 16'h0000, PC value loaded on reset.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- imem_rdy  in  1  instruction word at pc is valid this cycle; low = stall
- halt  in  1  decoded HLT from control
- ben  in  1  branch-enable (B or BR) from control
- br  in  1  1 = BR (register target), 0 = B (immediate target)
- cond  in  3  condition code, instr[11:9]
- imm9  in  9  signed word offset, instr[8:0]
- br_target  in  PC_W  rs value for BR
- flag_in  in  3  {Z,V,N} produced by ALU this cycle
- flag_we  in  3  per-bit write enable {Z,V,N}
- pc  out  PC_W  current fetch address
- pc_plus2  out  PC_W  pc+2, used for sequential fetch and as the PCS writeback value
- flags  out  3  registered {Z,V,N}
- branch_taken  out  1  combinational: branch resolves taken this cycle
- retire  out  1  combinational: instruction at pc completes this cycle
- halted  out  1  processor halted

Behaviour:
- Reset is asynchronous, active-high. On reset: pc=RESET_PC, flags=3'b000, state=RUN, halted=0. With the counters enabled, both counters are cleared. Reset mid-stall or while HALTED returns the block to RUN.
- Internal state is a 2-state FSM: RUN and HALTED. halted = (state==HALTED), registered.
- retire = (state==RUN) && imem_rdy.
- The PC changes only on retire, and is held otherwise (stall or HALTED).
- Next-PC priority on retire:
  - halt: pc holds (stays pointing at the HLT word); state goes to HALTED.
  - ben && taken && br: pc = br_target, used unmodified.
  - ben && taken && !br: pc = pc_plus2 + (sext(imm9) << 1).
  - otherwise: pc = pc_plus2.
- All PC arithmetic is modulo 2^PC_W. pc=16'hFFFE advances to 16'h0000.
- Condition codes are evaluated on the registered flags:
  - 000 NE: Z=0
  - 001 EQ: Z=1
  - 010 GT: Z=0 and N=0
  - 011 LT: N=1
  - 100 GE: Z=1, or (Z=0 and N=0)
  - 101 LE: Z=1 or N=1
  - 110 OV: V=1
  - 111 always taken
- branch_taken = retire && ben && cond_true(cond, flags) && !halt.
- Flag update: on retire only, each flags[i] loads flag_in[i] where flag_we[i]=1. Flags are not updated while stalled or HALTED.
- Simultaneous flag_we and ben in the same cycle: the branch resolves on the pre-update flags; the new flags become visible next cycle.
- halt together with ben: halt wins, no branch is taken.
- HALTED is sticky; only rst exits it. In HALTED, retire=0 and all inputs are ignored.

Optional Feature:
- Macro: PC_PERF_CNT_EN.
- When defined: adds ports retired_cnt (out, 32) and taken_cnt (out, 32).
  - retired_cnt increments on each retire; HLT counts.
  - taken_cnt increments on each branch_taken.
  - Both saturate at 32'hFFFFFFFF and clear on rst.
- When undefined: neither the ports nor the counter logic exist. All other behaviour is identical.

Decomposition:
- Shared package cpu_pkg holds:
  - condition-code localparams (COND_NE through COND_UNCOND)
  - flag bit indices (FLAG_Z=2, FLAG_V=1, FLAG_N=0)
  - the FSM state enum (ST_RUN, ST_HALTED)
  - the reset PC constant
- One combinational sub-module, pc_branch_cond (cond, flags -> cond_true). It is reused by the later pipelined version's branch unit.

Test Plan:
- Reset then sequential fetch: rst pulse, imem_rdy=1 for 4 cycles, no ben -> pc = 0000, 0002, 0004, 0006; flags=000; halted=0.
- B with negative offset: flags Z=1, pc=0010, ben=1, br=0, cond=001, imm9=9'h1FC -> branch_taken=1, next pc = 0012 - 8 = 000A. Repeat with cond=000 -> not taken, pc=0012.
- BR, and flag/branch same cycle: flags=000, ben=1, br=1, cond=111, br_target=1234 -> pc=1234. Then with ben=1, cond=001, flag_we=3'b100, flag_in=3'b100 -> not taken (old Z=0); flags=100 next cycle.
- Stall: imem_rdy=0 for 3 cycles at pc=0040 with flag_we=111 -> pc stays 0040, flags unchanged, retire=0 throughout.
- Halt and reset: halt=1 at pc=0020 with ben=1, cond=111 -> halted=1 next cycle, pc stays 0020, no branch. Further inputs are ignored. Asserting rst asynchronously mid-cycle -> pc=0000 and halted=0 immediately.
- Wrap and counters (PC_PERF_CNT_EN): pc=FFFE, retire -> pc=0000. Run 5 retires including 2 taken branches -> retired_cnt=5, taken_cnt=2.
